// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: pixel-clock-enabled h/v counters, coordinate requests to the
// renderer, and a delay line that realigns sync/de with the colour the renderer returns.
module vga_timing_gen #(
    parameter int H_SYNC  = 96,
    parameter int H_BACK  = 48,
    parameter int H_VALID = 640,
    parameter int H_FRONT = 16,
    parameter int V_SYNC  = 2,
    parameter int V_BACK  = 33,
    parameter int V_VALID = 480,
    parameter int V_FRONT = 10,
    parameter bit HS_POL  = 1'b0,
    parameter bit VS_POL  = 1'b0,
    parameter int RGB_W   = 12,
    parameter int PIPE    = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ce,
    input  logic [RGB_W-1:0] pix_data,
    output logic             req_valid,
    output logic [9:0]       req_x,
    output logic [9:0]       req_y,
    output logic             hsync,
    output logic             vsync,
    output logic             de,
    output logic [RGB_W-1:0] rgb,
    output logic             frame_start,
    output logic             line_end
);
    localparam int H_TOTAL = H_SYNC + H_BACK + H_VALID + H_FRONT;
    localparam int V_TOTAL = V_SYNC + V_BACK + V_VALID + V_FRONT;
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);

    // Region bounds are one bit wider than the counters so the active end never overflows.
    localparam logic [HW:0]   H_SYNC_E = (HW+1)'(H_SYNC);
    localparam logic [HW:0]   H_ACT_S  = (HW+1)'(H_SYNC + H_BACK);
    localparam logic [HW:0]   H_ACT_E  = (HW+1)'(H_SYNC + H_BACK + H_VALID);
    localparam logic [VW:0]   V_SYNC_E = (VW+1)'(V_SYNC);
    localparam logic [VW:0]   V_ACT_S  = (VW+1)'(V_SYNC + V_BACK);
    localparam logic [VW:0]   V_ACT_E  = (VW+1)'(V_SYNC + V_BACK + V_VALID);
    localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
    localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
    localparam logic [HW-1:0] H_ORG    = H_ACT_S[HW-1:0];
    localparam logic [VW-1:0] V_ORG    = V_ACT_S[VW-1:0];

    typedef struct packed {
        logic hs;
        logic vs;
        logic act;
    } tbits_t;

    logic [HW-1:0] cnt_h_q, cnt_h_d;
    logic [VW-1:0] cnt_v_q, cnt_v_d;
    logic [HW:0]   h_ext;
    logic [VW:0]   v_ext;
    logic          h_sync_raw, v_sync_raw, h_act, v_act;
    tbits_t        stage_q  [PIPE+1];
    tbits_t        stage_in [PIPE+1];
    logic [RGB_W-1:0] rgb_q;

    always_comb begin
        cnt_h_d = cnt_h_q;
        cnt_v_d = cnt_v_q;
        if (ce) begin
            if (cnt_h_q == H_LAST) begin
                cnt_h_d = '0;
                cnt_v_d = (cnt_v_q == V_LAST) ? '0 : cnt_v_q + 1'b1;
            end else begin
                cnt_h_d = cnt_h_q + 1'b1;
            end
        end
    end

    assign h_ext      = {1'b0, cnt_h_q};
    assign v_ext      = {1'b0, cnt_v_q};
    assign h_sync_raw = (h_ext < H_SYNC_E);
    assign v_sync_raw = (v_ext < V_SYNC_E);
    assign h_act      = (h_ext >= H_ACT_S) && (h_ext < H_ACT_E);
    assign v_act      = (v_ext >= V_ACT_S) && (v_ext < V_ACT_E);

    assign req_valid   = h_act && v_act;
    assign req_x       = req_valid ? 10'(cnt_h_q - H_ORG) : '0;
    assign req_y       = req_valid ? 10'(cnt_v_q - V_ORG) : '0;
    assign frame_start = ce && (cnt_h_q == H_ORG) && (cnt_v_q == V_ORG);
    assign line_end    = ce && (cnt_h_q == H_LAST);

    // stage_in[PIPE] is the bit entering the last stage, i.e. the one pix_data belongs to now.
    always_comb begin
        stage_in[0] = {h_sync_raw, v_sync_raw, req_valid};
        for (int k = 1; k <= PIPE; k++) begin
            stage_in[k] = stage_q[k-1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_h_q <= '0;
            cnt_v_q <= '0;
            for (int k = 0; k <= PIPE; k++) begin
                stage_q[k] <= '0;
            end
            rgb_q <= '0;
        end else begin
            cnt_h_q <= cnt_h_d;
            cnt_v_q <= cnt_v_d;
            if (ce) begin
                for (int k = 0; k <= PIPE; k++) begin
                    stage_q[k] <= stage_in[k];
                end
                rgb_q <= stage_in[PIPE].act ? pix_data : '0;
            end
        end
    end

    assign hsync = stage_q[PIPE].hs ? HS_POL : ~HS_POL;
    assign vsync = stage_q[PIPE].vs ? VS_POL : ~VS_POL;
    assign de    = stage_q[PIPE].act;
    assign rgb   = rgb_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: two small-timing instances (active-low/PIPE=2 and active-high/PIPE=0)
// checked every clock against a raster model indexed by the ce-tick count since reset release.
module tb_vga_timing_gen;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, ce;
    logic [11:0] pix_a, pix_b;
    logic        rv_a, hs_a, vs_a, de_a, fs_a, le_a;
    logic        rv_b, hs_b, vs_b, de_b, fs_b, le_b;
    logic [9:0]  rx_a, ry_a, rx_b, ry_b;
    logic [11:0] rgb_a, rgb_b;

    vga_timing_gen #(
        .H_SYNC(2), .H_BACK(2), .H_VALID(4), .H_FRONT(2),
        .V_SYNC(1), .V_BACK(1), .V_VALID(3), .V_FRONT(1),
        .HS_POL(1'b0), .VS_POL(1'b0), .RGB_W(12), .PIPE(2)
    ) dut_a (
        .clk(clk), .rst_n(rst_n), .ce(ce), .pix_data(pix_a),
        .req_valid(rv_a), .req_x(rx_a), .req_y(ry_a),
        .hsync(hs_a), .vsync(vs_a), .de(de_a), .rgb(rgb_a),
        .frame_start(fs_a), .line_end(le_a)
    );

    vga_timing_gen #(
        .H_SYNC(2), .H_BACK(2), .H_VALID(4), .H_FRONT(2),
        .V_SYNC(1), .V_BACK(1), .V_VALID(3), .V_FRONT(1),
        .HS_POL(1'b1), .VS_POL(1'b1), .RGB_W(12), .PIPE(0)
    ) dut_b (
        .clk(clk), .rst_n(rst_n), .ce(ce), .pix_data(pix_b),
        .req_valid(rv_b), .req_x(rx_b), .req_y(ry_b),
        .hsync(hs_b), .vsync(vs_b), .de(de_b), .rgb(rgb_b),
        .frame_start(fs_b), .line_end(le_b)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int t;                      // ce ticks since reset release
    logic [11:0] hist [0:3];    // renderer answers, hist[0] = request of previous tick

    int first_fs, second_fs, le_cnt, first_de, rgb28, bhs1, fs_clks;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (tick %0d)", name, act, exp, t);
        end
    endtask

    // Porch pixels are poisoned so any leak into rgb shows up.
    function automatic logic [11:0] render(input logic v, input logic [9:0] x, input logic [9:0] y);
        return v ? {4'h0, y[3:0], x[3:0]} : 12'hFFF;
    endfunction

    task automatic check_req(input string tag, input logic rv, input logic [9:0] rx,
                             input logic [9:0] ry, input logic fs, input logic le);
        int h, v, ex, ey;
        bit act;
        h   = t % 10;
        v   = (t / 10) % 6;
        act = (h >= 4) && (h < 8) && (v >= 2) && (v < 5);
        ex  = act ? h - 4 : 0;
        ey  = act ? v - 2 : 0;
        check({tag, "_req_valid"}, int'(rv), int'(act));
        check({tag, "_req_x"}, int'(rx), ex);
        check({tag, "_req_y"}, int'(ry), ey);
        check({tag, "_frame_start"}, int'(fs), int'(ce && h == 4 && v == 2));
        check({tag, "_line_end"}, int'(le), int'(ce && h == 9));
    endtask

    task automatic check_out(input string tag, input int lag, input bit pol, input logic hs,
                             input logic vs, input logic d, input logic [11:0] c);
        int k, h, v, e_rgb;
        bit e_hs, e_vs, e_de;
        if (t < lag) begin
            e_hs = ~pol; e_vs = ~pol; e_de = 1'b0; e_rgb = 0;
        end else begin
            k     = t - lag;
            h     = k % 10;
            v     = (k / 10) % 6;
            e_hs  = (h < 2) ? pol : ~pol;
            e_vs  = (v < 1) ? pol : ~pol;
            e_de  = (h >= 4) && (h < 8) && (v >= 2) && (v < 5);
            e_rgb = e_de ? (((v - 2) << 4) | (h - 4)) : 0;
        end
        check({tag, "_hsync"}, int'(hs), int'(e_hs));
        check({tag, "_vsync"}, int'(vs), int'(e_vs));
        check({tag, "_de"}, int'(d), int'(e_de));
        check({tag, "_rgb"}, int'(c), e_rgb);
    endtask

    task automatic clear_pins();
        first_fs = -1; second_fs = -1; le_cnt = 0; first_de = -1;
        rgb28 = -1; bhs1 = -1; fs_clks = 0;
    endtask

    task automatic cycle(input logic ce_v, input logic rst_v);
        @(negedge clk);
        ce = ce_v;
        rst_n = rst_v;
        if (!rst_v) begin
            t = 0;
            for (int i = 0; i < 4; i++) hist[i] = 12'hFFF;
        end
        #1;
        pix_a = hist[1];
        pix_b = render(rv_b, rx_b, ry_b);
        check_req("a", rv_a, rx_a, ry_a, fs_a, le_a);
        check_req("b", rv_b, rx_b, ry_b, fs_b, le_b);
        check_out("a", 3, 1'b0, hs_a, vs_a, de_a, rgb_a);
        check_out("b", 1, 1'b1, hs_b, vs_b, de_b, rgb_b);
        if (rst_n) begin
            if (fs_a) begin
                fs_clks++;
                if (first_fs < 0) first_fs = t;
                else if (second_fs < 0) second_fs = t;
            end
            if (le_a && t < 60) le_cnt++;
            if (de_a && first_de < 0) first_de = t;
            if (ce && t == 28) rgb28 = int'(rgb_a);
            if (ce && t == 1) bhs1 = int'(hs_b);
        end
        if (rst_n && ce) begin
            for (int i = 3; i > 0; i--) hist[i] = hist[i-1];
            hist[0] = render(rv_a, rx_a, ry_a);
            t++;
        end
    endtask

    initial begin
        rst_n = 1'b0; ce = 1'b1; pix_a = '0; pix_b = '0; t = 0;
        for (int i = 0; i < 4; i++) hist[i] = 12'hFFF;

        // Full-rate run from reset.
        repeat (3) cycle(1'b1, 1'b0);
        clear_pins();
        repeat (130) cycle(1'b1, 1'b1);
        check("first_frame_start_tick", first_fs, 24);
        check("frame_period", second_fs - first_fs, 60);
        check("line_ends_per_frame", le_cnt, 6);
        check("first_de_tick", first_de, 27);
        check("rgb_tick28", rgb28, 'h001);
        check("b_hsync_tick1", bhs1, 1);

        // Reset asserted mid-active at tick 33, then the sequence must repeat.
        repeat (33) cycle(1'b1, 1'b1);
        repeat (3) cycle(1'b1, 1'b0);
        clear_pins();
        repeat (90) cycle(1'b1, 1'b1);
        check("restart_first_frame_start", first_fs, 24);
        check("restart_first_de_tick", first_de, 27);

        // ce on every 4th clock: two frames of 60 ticks.
        repeat (2) cycle(1'b1, 1'b0);
        clear_pins();
        for (int i = 0; i < 480; i++) cycle((i % 4) == 0, 1'b1);
        check("slow_ce_frame_start_clocks", fs_clks, 2);
        check("slow_ce_first_frame_start", first_fs, 24);
        check("slow_ce_tick_count", t, 120);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
